// File: rtl/imem_arb_pkg.sv
// ============================================================================
// Module   : imem_arb_pkg
// Purpose  : Shared types and constants for the instruction-memory arbiter:
//            FSM state encoding, requester port identifiers, watchdog counter
//            width and a saturating-increment helper for the statistics block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [0:0] {
        RR   = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Requester identifiers (F = core fetch, L = loader/debug)
    typedef enum logic [0:0] {
        PORT_F = 1'b0,
        PORT_L = 1'b1
    } port_e;

    // Width of the fetch-starvation watchdog counter (MAX_LOCK <= 255)
    localparam int WAIT_W = 8;

    // 16-bit increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_arb_rsp.sv
// ============================================================================
// Module   : imem_arb_rsp
// Purpose  : Read-response return path. Remembers whether the previous cycle
//            accepted a memory read and which port won it, then presents the
//            memory read data to that port only, for exactly one cycle.
// Ports    : i_clk, i_rst_n        - clock / async active-low reset
//            i_rd_acc              - a read was accepted this cycle
//            i_rd_port             - port that won that read
//            i_mem_rdata           - memory data (valid 1 cycle after read)
//            o_f_rvalid/o_f_rdata  - fetch response (rdata 0 when not valid)
//            o_l_rvalid/o_l_rdata  - loader response (rdata 0 when not valid)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_arb_rsp
    import imem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_acc,
    input  port_e             i_rd_port,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_f_rvalid,
    output logic [DATA_W-1:0] o_f_rdata,
    output logic              o_l_rvalid,
    output logic [DATA_W-1:0] o_l_rdata
);

    logic  r_pend;
    port_e r_port;

    // Reset clears the pending flag, so a read in flight at reset never
    // produces a response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= 1'b0;
            r_port <= PORT_F;
        end else begin
            r_pend <= i_rd_acc;
            if (i_rd_acc) begin
                r_port <= i_rd_port;
            end
        end
    end

    assign o_f_rvalid = r_pend && (r_port == PORT_F);
    assign o_l_rvalid = r_pend && (r_port == PORT_L);
    assign o_f_rdata  = o_f_rvalid ? i_mem_rdata : '0;
    assign o_l_rdata  = o_l_rvalid ? i_mem_rdata : '0;

endmodule

`default_nettype wire

// File: rtl/imem_arbiter.sv
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares one instruction memory between the core fetch port (F,
//            read-only) and the loader/debug port (L, read/write). Round-robin
//            arbitration; L may lock the memory for burst programming, and a
//            watchdog forces the lock open after F has waited MAX_LOCK
//            consecutive cycles.
// Ports    : i_clk, i_rst_n                 - clock / async active-low reset
//            i_f_req, i_f_addr, o_f_gnt     - fetch request handshake
//            o_f_rvalid, o_f_rdata          - fetch read response
//            i_l_req, i_l_we, i_l_lock,
//            i_l_addr, i_l_wdata, o_l_gnt   - loader request handshake
//            o_l_rvalid, o_l_rdata          - loader read response
//            o_mem_en/we/addr/wdata         - memory request (combinational)
//            i_mem_rdata                    - memory data, 1-cycle latency
//            o_stat_*                       - only with IMEM_ARB_STATS_EN
// Options  : `define IMEM_ARB_STATS_EN adds 16-bit saturating counters for
//            F grants, L grants and conflict cycles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_f_req,
    input  logic [ADDR_W-1:0] i_f_addr,
    output logic              o_f_gnt,
    output logic              o_f_rvalid,
    output logic [DATA_W-1:0] o_f_rdata,
    input  logic              i_l_req,
    input  logic              i_l_we,
    input  logic              i_l_lock,
    input  logic [ADDR_W-1:0] i_l_addr,
    input  logic [DATA_W-1:0] i_l_wdata,
    output logic              o_l_gnt,
    output logic              o_l_rvalid,
    output logic [DATA_W-1:0] o_l_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [15:0]       o_stat_f_grants,
    output logic [15:0]       o_stat_l_grants,
    output logic [15:0]       o_stat_conflicts
`endif
);

    localparam logic [WAIT_W-1:0] c_max_lock = WAIT_W'(MAX_LOCK);

    arb_state_e        r_state,    w_state_nxt;
    port_e             r_rr_last,  w_rr_last_nxt;
    logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              w_f_gnt, w_l_gnt;
    logic              w_f_acc, w_l_acc;

    assign w_wait_inc = r_wait_cnt + 1'b1;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RR;
            r_rr_last  <= PORT_L;      // F wins the first conflict
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_last  <= w_rr_last_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Grant decision and next state
    // ------------------------------------------------------------------
    always_comb begin
        w_f_gnt       = 1'b0;
        w_l_gnt       = 1'b0;
        w_state_nxt   = r_state;
        w_rr_last_nxt = r_rr_last;
        w_wait_nxt    = '0;

        case (r_state)
            RR: begin
                if (i_f_req && (!i_l_req || (r_rr_last == PORT_L))) begin
                    w_f_gnt = 1'b1;
                end else if (i_l_req) begin
                    w_l_gnt = 1'b1;
                end

                if (w_f_gnt) begin
                    w_rr_last_nxt = PORT_F;
                end
                if (w_l_gnt) begin
                    w_rr_last_nxt = PORT_L;
                    if (i_l_lock) begin
                        w_state_nxt = LOCK;
                    end
                end
            end

            LOCK: begin
                w_l_gnt = i_l_req;
                // Every way out of LOCK leaves L as the last winner, so the
                // next conflict goes to F.
                w_rr_last_nxt = PORT_L;
                // Counts consecutive F wait cycles; an idle F clears it.
                w_wait_nxt = i_f_req ? w_wait_inc : '0;

                // Unlock and watchdog expiry may coincide; both simply
                // return to RR.
                if ((w_l_gnt && !i_l_lock) ||
                    (i_f_req && (w_wait_inc == c_max_lock))) begin
                    w_state_nxt = RR;
                    w_wait_nxt  = '0;
                end
            end

            default: begin
                w_state_nxt = RR;
            end
        endcase
    end

    // Grants are forced low while reset is asserted so every output reads 0.
    assign w_f_acc = w_f_gnt & i_rst_n;
    assign w_l_acc = w_l_gnt & i_rst_n;

    assign o_f_gnt = w_f_acc;
    assign o_l_gnt = w_l_acc;

    // ------------------------------------------------------------------
    // Memory request: the winner's request, combinationally
    // ------------------------------------------------------------------
    assign o_mem_en    = w_f_acc | w_l_acc;
    assign o_mem_we    = w_l_acc & i_l_we;
    assign o_mem_addr  = w_f_acc ? i_f_addr :
                         (w_l_acc ? i_l_addr : '0);
    assign o_mem_wdata = (w_l_acc & i_l_we) ? i_l_wdata : '0;

    // ------------------------------------------------------------------
    // Read response path
    // ------------------------------------------------------------------
    imem_arb_rsp #(
        .DATA_W (DATA_W)
    ) u_rsp (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_rd_acc    (w_f_acc | (w_l_acc & ~i_l_we)),
        .i_rd_port   (w_l_acc ? PORT_L : PORT_F),
        .i_mem_rdata (i_mem_rdata),
        .o_f_rvalid  (o_f_rvalid),
        .o_f_rdata   (o_f_rdata),
        .o_l_rvalid  (o_l_rvalid),
        .o_l_rdata   (o_l_rdata)
    );

`ifdef IMEM_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters (saturating)
    // ------------------------------------------------------------------
    logic [15:0] r_stat_f, r_stat_l, r_stat_c;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_f <= '0;
            r_stat_l <= '0;
            r_stat_c <= '0;
        end else begin
            if (w_f_acc) begin
                r_stat_f <= sat_inc16(r_stat_f);
            end
            if (w_l_acc) begin
                r_stat_l <= sat_inc16(r_stat_l);
            end
            if (i_f_req && i_l_req) begin
                r_stat_c <= sat_inc16(r_stat_c);
            end
        end
    end

    assign o_stat_f_grants  = r_stat_f;
    assign o_stat_l_grants  = r_stat_l;
    assign o_stat_conflicts = r_stat_c;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_arbiter.sv
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Self-checking bench for imem_arbiter (MAX_LOCK = 4). A reference
//            model of the arbitration rules predicts grants and memory
//            requests per cycle and queues expected read responses; a
//            separate monitor pops and compares them when rvalid appears.
//            Stat checks are compiled in with IMEM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_LOCK = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              f_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic              f_gnt, f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [ADDR_W-1:0] l_addr = '0;
    logic [DATA_W-1:0] l_wdata = '0;
    logic              l_gnt, l_rvalid;
    logic [DATA_W-1:0] l_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
`ifdef IMEM_ARB_STATS_EN
    logic [15:0]       st_f, st_l, st_c;
`endif

    always #5 clk = ~clk;

    imem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_f_req     (f_req),
        .i_f_addr    (f_addr),
        .o_f_gnt     (f_gnt),
        .o_f_rvalid  (f_rvalid),
        .o_f_rdata   (f_rdata),
        .i_l_req     (l_req),
        .i_l_we      (l_we),
        .i_l_lock    (l_lock),
        .i_l_addr    (l_addr),
        .i_l_wdata   (l_wdata),
        .o_l_gnt     (l_gnt),
        .o_l_rvalid  (l_rvalid),
        .o_l_rdata   (l_rdata),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
`ifdef IMEM_ARB_STATS_EN
        ,
        .o_stat_f_grants  (st_f),
        .o_stat_l_grants  (st_l),
        .o_stat_conflicts (st_c)
`endif
    );

    // ------------------------------------------------------------------
    // Memory device: 1-cycle read latency
    // ------------------------------------------------------------------
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
    endfunction

    logic [31:0] dev_mem [logic [31:0]];

    always @(posedge clk) begin
        if (mem_en && mem_we) dev_mem[mem_addr] = mem_wdata;
    end

    always @(posedge clk) begin
        if (mem_en && !mem_we)
            mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_word(mem_addr);
    end

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic        lock;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        int          cyc;
        logic [31:0] data;
    } exp_t;

    req_t fq[$], lq[$];
    req_t f_cur = '0, l_cur = '0;
    bit   f_act = 0, l_act = 0;
    exp_t f_exp[$], l_exp[$];

    // Reference model state, in terms of the arbitration rules
    logic [31:0] ref_mem [logic [31:0]];
    bit m_locked  = 0;
    bit m_favor_f = 1;   // who wins the next conflict while unlocked
    int m_fwait   = 0;   // consecutive cycles F has waited under lock
    int m_conf = 0, m_fg = 0, m_lg = 0;
    int f_wait_obs = 0, last_f_wait = 0;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : v[15:0];
    endfunction

    // ------------------------------------------------------------------
    // One bus cycle: drive, predict, compare, update the model
    // ------------------------------------------------------------------
    task automatic step();
        bit fr, lr, gf, gl;
        logic [31:0] ea;
        @(posedge clk);
        #1;
        if (!f_act && fq.size() > 0) begin f_cur = fq.pop_front(); f_act = 1; end
        if (!l_act && lq.size() > 0) begin l_cur = lq.pop_front(); l_act = 1; end
        f_req   = f_act;
        f_addr  = f_cur.addr;
        l_req   = l_act;
        l_we    = l_cur.we;
        l_lock  = l_cur.lock;
        l_addr  = l_cur.addr;
        l_wdata = l_cur.wdata;
        #2;
        fr = f_act; lr = l_act; gf = 0; gl = 0;
        if (!m_locked) begin
            if (fr && (!lr || m_favor_f)) gf = 1;
            else if (lr)                  gl = 1;
        end else begin
            gl = lr;
        end

        check("f_gnt", f_gnt, gf);
        check("l_gnt", l_gnt, gl);
        check("mem_en", mem_en, gf | gl);
        check("mem_we", mem_we, gl & l_cur.we);
        ea = gf ? f_cur.addr : (gl ? l_cur.addr : 32'h0);
        check("mem_addr", mem_addr, ea);
        if (gl && l_cur.we) check("mem_wdata", mem_wdata, l_cur.wdata);
`ifdef IMEM_ARB_STATS_EN
        check("stat_f_grants",  st_f, sat16(m_fg));
        check("stat_l_grants",  st_l, sat16(m_lg));
        check("stat_conflicts", st_c, sat16(m_conf));
`endif

        if (fr && !f_gnt) f_wait_obs++;
        if (f_gnt) begin last_f_wait = f_wait_obs; f_wait_obs = 0; end

        if (fr && lr) m_conf++;
        if (gf) m_fg++;
        if (gl) m_lg++;

        if (gf) f_exp.push_back('{cyc: cyc + 1, data: ref_read(f_cur.addr)});
        if (gl) begin
            if (l_cur.we) ref_mem[l_cur.addr] = l_cur.wdata;
            else          l_exp.push_back('{cyc: cyc + 1, data: ref_read(l_cur.addr)});
        end

        if (!m_locked) begin
            if (gf) m_favor_f = 0;
            if (gl) begin
                m_favor_f = 1;
                if (l_cur.lock) begin m_locked = 1; m_fwait = 0; end
            end
        end else begin
            m_fwait = fr ? m_fwait + 1 : 0;
            if ((gl && !l_cur.lock) || m_fwait == MAX_LOCK) begin
                m_locked = 0; m_favor_f = 1; m_fwait = 0;
            end
        end

        if (gf) f_act = 0;
        if (gl) l_act = 0;
    endtask

    // ------------------------------------------------------------------
    // Response monitor (decoupled from stimulus)
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        if (f_rvalid) begin
            if (f_exp.size() == 0) check("f_rvalid_unexpected", 1, 0);
            else begin
                e = f_exp.pop_front();
                check("f_rvalid_cycle", cyc, e.cyc);
                check("f_rdata", f_rdata, e.data);
            end
        end else begin
            check("f_rdata_idle", f_rdata, 0);
            if (f_exp.size() > 0 && f_exp[0].cyc <= cyc) begin
                e = f_exp.pop_front();
                check("f_rvalid_missing", 0, 1);
            end
        end
        if (l_rvalid) begin
            if (l_exp.size() == 0) check("l_rvalid_unexpected", 1, 0);
            else begin
                e = l_exp.pop_front();
                check("l_rvalid_cycle", cyc, e.cyc);
                check("l_rdata", l_rdata, e.data);
            end
        end else begin
            check("l_rdata_idle", l_rdata, 0);
            if (l_exp.size() > 0 && l_exp[0].cyc <= cyc) begin
                e = l_exp.pop_front();
                check("l_rvalid_missing", 0, 1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic apply_reset();
        rst_n = 1'b0;
        fq.delete(); lq.delete();
        f_act = 0; l_act = 0;
        f_cur = '0; l_cur = '0;
        f_req = 0; l_req = 0; l_we = 0; l_lock = 0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        f_exp.delete(); l_exp.delete();
        m_locked = 0; m_favor_f = 1; m_fwait = 0;
        m_conf = 0; m_fg = 0; m_lg = 0;
        f_wait_obs = 0; last_f_wait = 0;
        repeat (2) @(posedge clk);
        #3;
        check("reset_outputs_zero",
              {f_gnt, f_rvalid, l_gnt, l_rvalid, mem_en, mem_we,
               |f_rdata, |l_rdata, |mem_addr, |mem_wdata}, 0);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while ((f_act || l_act || fq.size() > 0 || lq.size() > 0) && n < 500) begin
            step();
            n++;
        end
        check("drain_bound", n < 500, 1);
        step();
        step();
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic we, input logic lk, input logic [31:0] wd);
        req_t r;
        r.addr = a; r.we = we; r.lock = lk; r.wdata = wd;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        // Reset with a read outstanding: no response may follow
        apply_reset();
        fq.push_back(mk(32'h64, 0, 0, 0));
        step();
        apply_reset();
        repeat (3) step();

        // Single requester, back-to-back fetches
        for (int a = 32'h64; a <= 32'h73; a++) fq.push_back(mk(a, 0, 0, 0));
        drain();

        // Contention from reset: F first, then alternating
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            fq.push_back(mk(32'h400 + 4 * i, 0, 0, 0));
            lq.push_back(mk(32'h800 + 4 * i, 0, 0, 0));
        end
        drain();

        // Loader lock burst with F waiting from the second cycle
        for (int i = 0; i < 4; i++) lq.push_back(mk(32'h100 + 4 * i, 1, 1, 32'hC0DE_0000 + i));
        lq.push_back(mk(32'h110, 1, 0, 32'hC0DE_0004));
        step();
        fq.push_back(mk(32'h300, 0, 0, 0));
        drain();
        check("lock_f_wait", last_f_wait, MAX_LOCK);
        for (int i = 0; i < 5; i++) lq.push_back(mk(32'h100 + 4 * i, 0, 0, 0));
        drain();

        // Watchdog: L locks then goes idle while F keeps requesting
        lq.push_back(mk(32'h180, 1, 1, 32'hFEED_BEEF));
        step();
        fq.push_back(mk(32'h200, 0, 0, 0));
        drain();
        check("watchdog_f_wait", last_f_wait, MAX_LOCK);
        fq.push_back(mk(32'h180, 0, 0, 0));
        drain();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!f_act && fq.size() == 0 && $urandom_range(0, 99) < 60)
                fq.push_back(mk($urandom_range(0, 31) * 4, 0, 0, 0));
            if (!l_act && lq.size() == 0 && $urandom_range(0, 99) < 45)
                lq.push_back(mk($urandom_range(0, 31) * 4, 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 99) < 25), $urandom));
            step();
        end
        drain();

        check("f_exp_empty", f_exp.size(), 0);
        check("l_exp_empty", l_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
